otn_tx_framer: RTL and testbench

- Transmit-side serial OTN framer, directly upstream of the serial receive transceiver.
- Buffers one frame of mapped payload bytes from the mapper.
- Prepends the 48-bit frame start pattern and drives the frame one bit per clock on the serial line.
- With ARQ enabled, waits for the 3-bit serial ACK from the receiver and retransmits the buffered frame on a bad, malformed or missing ACK, up to a retry limit.

---
 rtl/otn_tx_framer_if.sv | 19 +
 rtl/otn_tx_framer.sv | 235 +++++++++++++++++++++++
 tb/tb_otn_tx_framer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otn_tx_framer_if.sv
// Byte handshake between the mapper and the serial OTN transmit framer.
// A byte transfers on any clock where valid and ready are both high.
interface otn_tx_framer_if;
   logic [7:0] i_frame_data;
   logic       i_frame_data_valid;
   logic       o_frame_data_ready;

   modport master (
      output i_frame_data,
      output i_frame_data_valid,
      input  o_frame_data_ready
   );

   modport slave (
      input  i_frame_data,
      input  i_frame_data_valid,
      output o_frame_data_ready
   );
endinterface

// File: rtl/otn_tx_framer.sv
// Serial OTN transmit framer: buffers one payload frame, sends start pattern + payload MSB first,
// and optionally retransmits on a bad/missing serial ACK. `define OTN_TX_STATS_EN adds retx/drop counters.
module otn_tx_framer #(
   parameter int unsigned PAYLOAD_BYTES = 4158,
   parameter logic [47:0] FRAME_START   = 48'hF6F6F6282828,
   parameter int unsigned ACK_TIMEOUT   = 64,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   otn_tx_framer_if.slave up,
   output logic        o_otn_tx_data,
   input  logic        i_otn_rx_ack,
   input  logic        i_arq_en,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_frame_drop
`ifdef OTN_TX_STATS_EN
   ,
   output logic [15:0] o_retx_count,
   output logic [15:0] o_drop_count
`endif
);

   localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {LOAD, SEND_HDR, SEND_DATA, ACK_WAIT, ACK_BIT, ACK_STOP} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [7:0]         shift_q, shift_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic               arq_q, arq_d;
   logic               good_q, good_d;
   logic               tx_q, tx_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               drop_q, drop_d;
   logic               ack_meta_q, ack_s_q;
   logic               wr_en, attempt_fail;
   logic [7:0]         rd_byte;
   logic [7:0]         buf_mem [PAYLOAD_BYTES];
`ifdef OTN_TX_STATS_EN
   logic [15:0]        retx_cnt_q, retx_cnt_d, drop_cnt_q, drop_cnt_d;
`endif

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      timer_d      = timer_q;
      retry_d      = retry_q;
      arq_d        = arq_q;
      good_d       = good_q;
      tx_d         = 1'b0;
      done_d       = 1'b0;
      drop_d       = 1'b0;
      wr_en        = 1'b0;
      attempt_fail = 1'b0;
      rd_byte      = '0;
`ifdef OTN_TX_STATS_EN
      retx_cnt_d   = retx_cnt_q;
      drop_cnt_d   = drop_cnt_q;
`endif

      case (state_q)
         LOAD: begin
            if (up.i_frame_data_valid && ready_q) begin
               wr_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  cnt_d   = '0;
                  arq_d   = i_arq_en;
                  retry_d = '0;
                  state_d = SEND_HDR;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         SEND_HDR: begin
            if (cnt_q == 6'd47) begin
               cnt_d   = '0;
               state_d = SEND_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SEND_DATA: begin
            if (cnt_q == 6'd7) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (arq_q) begin
                     timer_d = '0;
                     state_d = ACK_WAIT;
                  end else begin
                     done_d  = 1'b1;
                     state_d = LOAD;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACK_WAIT: begin
            // A start bit on the last tick still wins over the timeout.
            if (!ack_s_q)                    state_d = ACK_BIT;
            else if (timer_q == LAST_TICK)   attempt_fail = 1'b1;
            else                             timer_d = timer_q + 1'b1;
         end
         ACK_BIT: begin
            good_d  = ack_s_q;
            state_d = ACK_STOP;
         end
         ACK_STOP: begin
            if (!ack_s_q && good_q) begin
               done_d  = 1'b1;
               state_d = LOAD;
            end else begin
               attempt_fail = 1'b1;
            end
         end
         default: state_d = LOAD;
      endcase

      if (attempt_fail) begin
         if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = SEND_HDR;
`ifdef OTN_TX_STATS_EN
            if (retx_cnt_q != 16'hFFFF) retx_cnt_d = retx_cnt_q + 1'b1;
`endif
         end else begin
            drop_d  = 1'b1;
            state_d = LOAD;
`ifdef OTN_TX_STATS_EN
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
`endif
         end
      end

      // The line bit is computed from the next position so it is registered with the state.
      if (state_d == SEND_HDR) begin
         tx_d = FRAME_START[6'd47 - cnt_d];
      end else if (state_d == SEND_DATA) begin
         if (cnt_d == '0) begin
            rd_byte = buf_mem[idx_d];
            tx_d    = rd_byte[7];
            shift_d = {rd_byte[6:0], 1'b0};
         end else begin
            tx_d    = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
         end
      end

      ready_d = (state_d == LOAD);
      busy_d  = (state_d != LOAD);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= LOAD;
         idx_q      <= '0;
         cnt_q      <= '0;
         shift_q    <= '0;
         timer_q    <= '0;
         retry_q    <= '0;
         arq_q      <= 1'b0;
         good_q     <= 1'b0;
         tx_q       <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
         ack_meta_q <= 1'b1;
         ack_s_q    <= 1'b1;
`ifdef OTN_TX_STATS_EN
         retx_cnt_q <= '0;
         drop_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         arq_q      <= arq_d;
         good_q     <= good_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
         ack_meta_q <= i_otn_rx_ack;
         ack_s_q    <= ack_meta_q;
`ifdef OTN_TX_STATS_EN
         retx_cnt_q <= retx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
`endif
      end
   end

   // NOTE: the payload buffer has no reset; every byte is rewritten before it is read.
   always_ff @(posedge i_clk) begin
      if (wr_en) buf_mem[idx_q] <= up.i_frame_data;
   end

   assign up.o_frame_data_ready = ready_q;
   assign o_otn_tx_data         = tx_q;
   assign o_busy                = busy_q;
   assign o_frame_done          = done_q;
   assign o_frame_drop          = drop_q;
`ifdef OTN_TX_STATS_EN
   assign o_retx_count          = retx_cnt_q;
   assign o_drop_count          = drop_cnt_q;
`endif

endmodule

// File: tb/tb_otn_tx_framer.sv
// Self-checking bench for otn_tx_framer (8-byte frames): a per-cycle timeline model of the line,
// handshake and pulse outputs is built from the frame/ACK rules and compared every cycle.
module tb_otn_tx_framer;
   localparam int P    = 8;
   localparam int L    = 48 + 8 * P;
   localparam int TO   = 64;
   localparam int MAXR = 3;
   localparam int MAXT = 1024;
   localparam logic [47:0] FS = 48'hF6F6F6282828;

   typedef enum int {R_NONE, R_GOOD, R_BAD, R_MALF} resp_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic ack    = 1'b1;
   logic arq_en = 1'b0;
   logic tx, busy, done, drop;
`ifdef OTN_TX_STATS_EN
   logic [15:0] retx_cnt, drop_cnt;
`endif

   otn_tx_framer_if up_if ();

   otn_tx_framer #(.PAYLOAD_BYTES(P)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .up            (up_if),
      .o_otn_tx_data (tx),
      .i_otn_rx_ack  (ack),
      .i_arq_en      (arq_en),
      .o_busy        (busy),
      .o_frame_done  (done),
      .o_frame_drop  (drop)
`ifdef OTN_TX_STATS_EN
      ,
      .o_retx_count  (retx_cnt),
      .o_drop_count  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] pay [P];
   resp_t      resp [MAXR+1];
   int         lag  [MAXR+1];
   logic [4:0] exp_out [MAXT];   // {line, ready, busy, done, drop} per cycle after the last handshake
   logic       ack_plan [MAXT];  // receiver line value driven during each cycle
   logic [L-1:0] last_cap;
   int model_end, frame_retx, frame_drops;
   int tot_retx  = 0;
   int tot_drops = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic frame_bit(input int k);
      logic [7:0] b;
      if (k < 48) return FS[47 - k];
      b = pay[(k - 48) / 8];
      return b[7 - ((k - 48) % 8)];
   endfunction

   // Cycle 1 is the cycle after the last payload handshake. An ACK start bit driven in
   // cycle t0 is decided in cycle t0+5 (two sync stages, start, data, stop).
   task automatic build_model(input logic arq);
      int s, w, t0, a;
      logic ok;
      for (int t = 0; t < MAXT; t++) begin
         exp_out[t]  = 5'b00100;
         ack_plan[t] = 1'b1;
      end
      s = 1; a = 0; frame_retx = 0; frame_drops = 0;
      while (1) begin
         for (int k = 0; k < L; k++) exp_out[s + k][4] = frame_bit(k);
         w = s + L;
         if (!arq) begin
            model_end = w; ok = 1'b1;
         end else if (resp[a] == R_NONE || lag[a] > TO - 2) begin
            model_end = w + TO; ok = 1'b0;
         end else begin
            t0 = w - 1 + lag[a];
            ack_plan[t0]     = 1'b0;
            ack_plan[t0 + 1] = (resp[a] != R_BAD);
            ack_plan[t0 + 2] = (resp[a] == R_MALF);
            model_end = t0 + 5;
            ok = (resp[a] == R_GOOD);
         end
         if (ok) begin
            exp_out[model_end] = 5'b01010;
            break;
         end
         if (a == MAXR) begin
            exp_out[model_end] = 5'b01001;
            frame_drops = 1;
            break;
         end
         a++;
         frame_retx++;
         s = model_end;
      end
   endtask

   task automatic apply_reset(input string tag);
      up_if.i_frame_data_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1 check({tag, " async reset outputs"},
               {tx, up_if.o_frame_data_ready, busy, done, drop}, 5'b00000);
      @(negedge clk);
      check({tag, " held in reset"}, {tx, up_if.o_frame_data_ready, busy, done, drop}, 5'b00000);
      rst_n = 1'b1;
      #1 check({tag, " first cycle after release"},
               {tx, up_if.o_frame_data_ready, busy, done, drop}, 5'b00000);
      @(negedge clk);
      check({tag, " ready after release"}, {tx, up_if.o_frame_data_ready, busy, done, drop}, 5'b01000);
      up_if.i_frame_data_valid = 1'b0;
      ack       = 1'b1;
      tot_retx  = 0;
      tot_drops = 0;
   endtask

   task automatic run_frame(input string tag, input logic arq, input int rst_at);
      int i, guard;
      build_model(arq);
      i = 0; guard = 0; arq_en = arq;
      while (i < P) begin
         @(negedge clk);
         check({tag, " load busy"}, busy, 1'b0);
         up_if.i_frame_data_valid = ($urandom_range(3) != 0);
         up_if.i_frame_data       = up_if.i_frame_data_valid ? pay[i] : 8'($urandom);
         if (up_if.i_frame_data_valid && up_if.o_frame_data_ready) i++;
         guard++;
         if (guard > 200) begin
            check({tag, " load ready timeout"}, 1'b0, 1'b1);
            return;
         end
      end
      for (int t = 1; t <= model_end; t++) begin
         @(negedge clk);
         check($sformatf("%s t=%0d {line,ready,busy,done,drop}", tag, t),
               {tx, up_if.o_frame_data_ready, busy, done, drop}, exp_out[t]);
         if (t <= L) last_cap[L - t] = tx;
         if (t == rst_at) begin
            apply_reset(tag);
            return;
         end
         ack    = ack_plan[t];
         arq_en = 1'($urandom);
         up_if.i_frame_data_valid = (t < model_end) ? 1'($urandom) : 1'b0;
         up_if.i_frame_data       = 8'($urandom);
      end
      tot_retx  += frame_retx;
      tot_drops += frame_drops;
`ifdef OTN_TX_STATS_EN
      check({tag, " retx count"}, retx_cnt, tot_retx[15:0]);
      check({tag, " drop count"}, drop_cnt, tot_drops[15:0]);
`endif
   endtask

   task automatic random_payload();
      for (int k = 0; k < P; k++) pay[k] = 8'($urandom);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [L-1:0] model_bits;
      up_if.i_frame_data_valid = 1'b0;
      up_if.i_frame_data       = 8'h00;
      repeat (2) @(negedge clk);
      check("reset values", {tx, up_if.o_frame_data_ready, busy, done, drop}, 5'b00000);
      rst_n = 1'b1;
      #1 check("ready low in first cycle after release", up_if.o_frame_data_ready, 1'b0);

      // ARQ off, bytes 01..08
      for (int k = 0; k < P; k++) pay[k] = 8'(k + 1);
      run_frame("arq_off", 1'b0, 0);
      for (int t = 1; t <= L; t++) model_bits[L - t] = exp_out[t][4];
      check("model frame bits", model_bits, {48'hF6F6F6282828, 64'h0102030405060708});
      check("model arq_off done cycle", model_end, 113);
      check("line bits arq_off", last_cap, {48'hF6F6F6282828, 64'h0102030405060708});

      // Good ACK twelve clocks after the last bit
      random_payload();
      resp[0] = R_GOOD; lag[0] = 12;
      run_frame("good_ack", 1'b1, 0);
      check("model good_ack done cycle", model_end, 129);

      // Two bad ACKs then a good one
      random_payload();
      resp[0] = R_BAD; resp[1] = R_BAD; resp[2] = R_GOOD;
      for (int a = 0; a <= MAXR; a++) lag[a] = $urandom_range(60, 1);
      run_frame("bad_bad_good", 1'b1, 0);
      check("model bad_bad_good retx", frame_retx, 2);

      // No ACK at all: four transmissions then drop
      random_payload();
      for (int a = 0; a <= MAXR; a++) resp[a] = R_NONE;
      run_frame("no_ack", 1'b1, 0);
      check("model no_ack drop cycle", model_end, 705);
      check("model no_ack drops", frame_drops, 1);

      // Malformed ACK (stop bit high) then good
      random_payload();
      resp[0] = R_MALF; resp[1] = R_GOOD; lag[0] = 5; lag[1] = 60;
      run_frame("malformed", 1'b1, 0);
      check("model malformed retx", frame_retx, 1);

      // Start bit seen on the final timeout tick
      random_payload();
      resp[0] = R_GOOD; lag[0] = 62;
      run_frame("late_start", 1'b1, 0);
      check("model late_start done cycle", model_end, 179);

      // Reset in the middle of SEND_DATA, then fresh frames
      for (int k = 0; k < P; k++) pay[k] = 8'hFF;
      resp[0] = R_GOOD; lag[0] = 10;
      run_frame("reset_mid", 1'b1, 48 + 8 * 3 + 2);
      random_payload();
      run_frame("after_reset", 1'b0, 0);
      random_payload();
      resp[0] = R_BAD; resp[1] = R_GOOD; lag[0] = 30; lag[1] = 7;
      run_frame("after_reset_arq", 1'b1, 0);

      // Randomized frames
      for (int f = 0; f < 12; f++) begin
         random_payload();
         for (int a = 0; a <= MAXR; a++) begin
            resp[a] = resp_t'($urandom_range(3));
            lag[a]  = $urandom_range(60, 1);
         end
         run_frame($sformatf("rand%0d", f), 1'($urandom), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
